// File: rtl/rv32i_pkg.sv
// rv32i_pkg: shared fetch-state encoding and RV32I constants
package rv32i_pkg;
  localparam int ILEN = 32;
  localparam logic [ILEN-1:0] RESET_PC_DEF = 32'h0000_0000;
  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_REQ   = 3'd1,
    S_WAIT  = 3'd2,
    S_ISSUE = 3'd3,
    S_EXEC  = 3'd4,
    S_ERR   = 3'd5
  } fetch_state_e;
endpackage

// File: rtl/fetch_unit_rv32i.sv
// fetch_unit_rv32i: RV32I PC register and fetch control between imem and decode
module fetch_unit_rv32i
  import rv32i_pkg::*;
#(
  parameter logic [ILEN-1:0] RESET_PC = RESET_PC_DEF,
  parameter int COUNT_W = 32
) (
  input  logic               clock,
  input  logic               reset,
  output logic               imem_req,
  output logic [ILEN-1:0]    imem_addr,
  input  logic               imem_gnt,
  input  logic               imem_rvalid,
  input  logic [ILEN-1:0]    imem_rdata,
  output logic               instr_valid,
  input  logic               instr_ready,
  output logic [ILEN-1:0]    instr,
  output logic [ILEN-1:0]    pc,
  output logic [ILEN-1:0]    pc_plus4,
  input  logic               pc_next_valid,
  input  logic [ILEN-1:0]    pc_next,
  output logic               misalign_err,
  output logic [COUNT_W-1:0] fetch_count
);
  fetch_state_e r_state, w_state_nxt;
  logic [ILEN-1:0] r_pc, r_instr;
  logic [COUNT_W-1:0] r_count;
  logic r_err;
  logic w_accept, w_upd, w_aligned;
  assign w_accept  = (r_state == S_ISSUE) && instr_ready;
  assign w_upd     = pc_next_valid && (w_accept || (r_state == S_EXEC));
  assign w_aligned = (pc_next[1:0] == 2'b00);
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:  w_state_nxt = S_REQ;
      S_REQ:   w_state_nxt = imem_gnt ? S_WAIT : S_REQ;
      S_WAIT:  w_state_nxt = imem_rvalid ? S_ISSUE : S_WAIT;
      S_ISSUE: w_state_nxt = instr_ready ? S_EXEC : S_ISSUE;
      S_EXEC:  w_state_nxt = S_EXEC;
      S_ERR:   w_state_nxt = S_ERR;
      default: w_state_nxt = S_IDLE;
    endcase
    if (w_upd) w_state_nxt = w_aligned ? S_REQ : S_ERR;
  end
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_state <= S_IDLE;
      r_pc    <= RESET_PC;
      r_instr <= '0;
      r_count <= '0;
      r_err   <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      if (w_upd && w_aligned) r_pc <= pc_next;
      if ((r_state == S_WAIT) && imem_rvalid) r_instr <= imem_rdata;
      if (w_accept) r_count <= r_count + COUNT_W'(1);
      if (w_upd && !w_aligned) r_err <= 1'b1;
    end
  end
  assign imem_req     = (r_state == S_REQ);
  assign imem_addr    = r_pc;
  assign instr_valid  = (r_state == S_ISSUE);
  assign instr        = r_instr;
  assign pc           = r_pc;
  assign pc_plus4     = r_pc + 32'd4;
  assign misalign_err = r_err;
  assign fetch_count  = r_count;
endmodule

// File: tb/tb_fetch_unit_rv32i.sv
// tb_fetch_unit_rv32i: directed scoreboard bench for the RV32I fetch unit
module tb_fetch_unit_rv32i;
  logic        clock = 0;
  logic        reset = 1;
  logic        imem_req, imem_gnt, imem_rvalid;
  logic [31:0] imem_addr, imem_rdata;
  logic        instr_valid, instr_ready = 0;
  logic [31:0] instr, pc, pc_plus4;
  logic        pc_next_valid = 0;
  logic [31:0] pc_next = 0;
  logic        misalign_err;
  logic [31:0] fetch_count;
  logic        gnt_en = 1, rv_en = 1;
  int          cyc = 0, inj_cyc = -10;
  int          total = 0, bad = 0, lat;
  logic [63:0] sb[$];

  fetch_unit_rv32i #(.RESET_PC(32'h0000_0100), .COUNT_W(32)) dut (
    .clock(clock), .reset(reset),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_gnt(imem_gnt),
    .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata),
    .instr_valid(instr_valid), .instr_ready(instr_ready), .instr(instr),
    .pc(pc), .pc_plus4(pc_plus4),
    .pc_next_valid(pc_next_valid), .pc_next(pc_next),
    .misalign_err(misalign_err), .fetch_count(fetch_count)
  );

  always #5 clock = ~clock;
  always @(posedge clock) cyc <= cyc + 1;
  assign imem_gnt = imem_req & gnt_en;

  function automatic logic [31:0] mem(input logic [31:0] a);
    return 32'h0050_0093 + (a - 32'h100);
  endfunction

  task automatic chk(input string n, input logic [31:0] a, input logic [31:0] e);
    total++;
    if (a !== e) begin
      bad++;
      $display("FAIL %s: got %h want %h", n, a, e);
    end
  endtask

  // memory answers one cycle after each grant; inj_cyc forces a stray rvalid
  initial begin
    logic g;
    logic [31:0] a;
    imem_rvalid = 0;
    imem_rdata  = 0;
    forever begin
      @(negedge clock);
      g = imem_req && imem_gnt && !reset;
      a = imem_addr;
      @(posedge clock);
      #1;
      imem_rvalid = (g && rv_en) || (cyc == inj_cyc);
      imem_rdata  = g ? mem(a) : 32'hDEAD_BEEF;
    end
  end

  always @(negedge clock) begin
    if (!reset && instr_valid && instr_ready) begin
      if (sb.size() == 0) begin
        total++;
        bad++;
        $display("FAIL sb_unexpected: got pc %h, want no handshake", pc);
      end else begin
        logic [63:0] e;
        e = sb.pop_front();
        chk("sb_pc", pc, e[63:32]);
        chk("sb_instr", instr, e[31:0]);
        chk("sb_pc_plus4", pc_plus4, e[63:32] + 32'd4);
      end
    end
  end

  task automatic push(input logic [31:0] p, input logic [31:0] i);
    sb.push_back({p, i});
  endtask

  task automatic issue(input logic [31:0] nxt, input bit same, input int stall,
                       input int exec_wait, input bit hold_gnt, input bit kill_rv,
                       output int l);
    logic [31:0] hp, hi, hc;
    l = 0;
    while (!instr_valid && l < 50) begin
      @(posedge clock);
      #1;
      l++;
    end
    if (!instr_valid) begin
      chk("issue_timeout", 32'(instr_valid), 32'd1);
      return;
    end
    hp = pc;
    hi = instr;
    hc = fetch_count;
    for (int k = 0; k < stall; k++) begin
      instr_ready = 0;
      @(posedge clock);
      #1;
      chk("stall_valid", 32'(instr_valid), 32'd1);
      chk("stall_pc", pc, hp);
      chk("stall_instr", instr, hi);
      chk("stall_count", fetch_count, hc);
    end
    instr_ready = 1;
    pc_next_valid = same;
    pc_next = nxt;
    if (hold_gnt) gnt_en = 0;
    if (kill_rv) rv_en = 0;
    @(posedge clock);
    #1;
    instr_ready = 0;
    pc_next_valid = 0;
    chk("count_inc", fetch_count, hc + 32'd1);
    chk("valid_drop", 32'(instr_valid), 32'd0);
    if (!same) begin
      pc_next = 32'h0000_0003;
      repeat (exec_wait) begin
        @(posedge clock);
        #1;
      end
      pc_next_valid = 1;
      pc_next = nxt;
      @(posedge clock);
      #1;
      pc_next_valid = 0;
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (2) @(posedge clock);
    #1;
    chk("rst_req", 32'(imem_req), 32'd0);
    chk("rst_valid", 32'(instr_valid), 32'd0);
    chk("rst_pc", pc, 32'h100);
    chk("rst_instr", instr, 32'h0);
    chk("rst_count", fetch_count, 32'h0);
    chk("rst_err", 32'(misalign_err), 32'd0);
    chk("rst_pc_plus4", pc_plus4, 32'h104);
    reset = 0;
    #1;
    chk("idle_req", 32'(imem_req), 32'd0);

    push(32'h100, 32'h0050_0093);
    issue(32'h104, 1, 0, 0, 0, 0, lat);
    push(32'h104, 32'h0050_0097);
    issue(32'h108, 1, 0, 0, 0, 0, lat);
    chk("lat_2", lat, 2);
    push(32'h108, 32'h0050_009B);
    issue(32'h10C, 1, 0, 0, 1, 0, lat);
    chk("lat_3", lat, 2);
    chk("count_3", fetch_count, 32'd3);

    for (int i = 0; i < 5; i++) begin
      chk("hold_req", 32'(imem_req), 32'd1);
      chk("hold_addr", imem_addr, 32'h10C);
      if (i == 4) gnt_en = 1;
      @(posedge clock);
      #1;
    end
    chk("hold_wait", 32'(imem_req), 32'd0);

    push(32'h10C, 32'h0050_009F);
    issue(32'h200, 0, 3, 2, 0, 0, lat);
    push(32'h200, 32'h0050_0193);
    issue(32'h1F0, 0, 0, 1, 0, 0, lat);
    chk("redir_req", 32'(imem_req), 32'd1);
    chk("redir_addr", imem_addr, 32'h1F0);
    chk("redir_plus4", pc_plus4, 32'h1F4);

    push(32'h1F0, 32'h0050_0183);
    issue(32'hFFFF_FFFC, 1, 0, 0, 0, 0, lat);
    chk("wrap_plus4", pc_plus4, 32'h0);
    push(32'hFFFF_FFFC, 32'h004F_FF8F);
    issue(32'h0, 1, 0, 0, 0, 0, lat);
    chk("wrap_addr", imem_addr, 32'h0);
    push(32'h0, 32'h004F_FF93);
    issue(32'h200, 0, 0, 0, 0, 0, lat);

    push(32'h200, 32'h0050_0193);
    issue(32'h202, 0, 0, 0, 0, 0, lat);
    for (int i = 0; i < 5; i++) begin
      pc_next_valid = 1;
      pc_next = 32'h300;
      chk("err_flag", 32'(misalign_err), 32'd1);
      chk("err_pc", pc, 32'h200);
      chk("err_req", 32'(imem_req), 32'd0);
      chk("err_valid", 32'(instr_valid), 32'd0);
      @(posedge clock);
      #1;
    end
    pc_next_valid = 0;
    chk("err_count", fetch_count, 32'd9);

    reset = 1;
    #1;
    chk("clr_err", 32'(misalign_err), 32'd0);
    chk("clr_pc", pc, 32'h100);
    @(posedge clock);
    #1;
    reset = 0;
    push(32'h100, 32'h0050_0093);
    issue(32'h104, 1, 0, 0, 0, 1, lat);
    chk("restart_lat", lat, 3);
    @(posedge clock);
    #1;
    chk("wait_req", 32'(imem_req), 32'd0);
    chk("wait_valid", 32'(instr_valid), 32'd0);

    reset = 1;
    @(posedge clock);
    #1;
    reset = 0;
    inj_cyc = cyc + 1;
    rv_en = 1;
    @(posedge clock);
    #1;
    chk("stale_valid0", 32'(instr_valid), 32'd0);
    chk("fresh_req", 32'(imem_req), 32'd1);
    chk("fresh_addr", imem_addr, 32'h100);
    @(posedge clock);
    #1;
    chk("stale_valid1", 32'(instr_valid), 32'd0);
    push(32'h100, 32'h0050_0093);
    issue(32'h104, 1, 0, 0, 0, 0, lat);
    chk("fresh_count", fetch_count, 32'd1);

    repeat (3) @(posedge clock);
    #1;
    chk("sb_empty", sb.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/fetch_unit_rv32i.md
Name: fetch_unit_rv32i

Overview:
- Holds the RV32I program counter and fetches instructions from instruction memory over a req/gnt/rvalid handshake.
- Presents each instruction and its PC to decode with a valid/ready handshake.
- Produces pc_plus4 (the PC+4 value consumed by the branch-resolution stage).
- Accepts the resolved next PC back from that stage and performs the PC update. This is the PC register plus fetch control directly downstream of branch resolution.

Parameters:
RESET_PC, 32'h0000_0000, PC value loaded on reset.
COUNT_W, 32, width of fetch_count.

Ports:
clock  input  1  system clock, rising edge
reset  input  1  asynchronous, active-high reset
imem_req  output  1  fetch request to instruction memory
imem_addr  output  32  fetch address, equals pc
imem_gnt  input  1  memory accepted request this cycle
imem_rvalid  input  1  read data valid
imem_rdata  input  32  instruction word
instr_valid  output  1  instr/pc valid to decode
instr_ready  input  1  decode accepts instruction
instr  output  32  fetched instruction (registered)
pc  output  32  PC of instr
pc_plus4  output  32  pc + 4, modulo 2^32
pc_next_valid  input  1  pc_next is resolved
pc_next  input  32  next PC from branch resolution (PC+4 or target)
misalign_err  output  1  sticky: pc_next not 4-byte aligned
fetch_count  output  COUNT_W  instructions accepted by decode

Behaviour:
- Reset is asynchronous and active-high; the design uses one clock. While reset is asserted or in the cycle after deassertion:
  - state=S_IDLE, pc=RESET_PC, instr=0, fetch_count=0, misalign_err=0.
  - imem_req=0, instr_valid=0.
- S_IDLE: advance to S_REQ unconditionally on the next edge.
- S_REQ: imem_req=1, imem_addr=pc. imem_req stays high until imem_gnt; then go to S_WAIT. imem_rvalid is ignored in this state, which discards stale responses after a mid-operation reset.
- S_WAIT: imem_req=0. On imem_rvalid: instr<=imem_rdata, go to S_ISSUE. There is no timeout.
- S_ISSUE: instr_valid=1; instr and pc are held stable until accepted. On instr_ready:
  - fetch_count increments, wrapping at 2^COUNT_W.
  - If pc_next_valid is also high in the same cycle (single-cycle core), apply the PC update rule and go directly to S_REQ (or S_ERR).
  - Otherwise go to S_EXEC.
- S_EXEC: instr_valid=0. Wait for pc_next_valid, then apply the PC update rule.
- PC update rule:
  - If pc_next[1:0]==2'b00: pc<=pc_next, go to S_REQ.
  - Otherwise: pc is unchanged, misalign_err<=1, go to S_ERR.
- S_ERR: terminal until reset. imem_req=0, instr_valid=0.
- pc_next_valid is ignored in S_IDLE, S_REQ, S_WAIT and S_ERR.
- pc_plus4 is combinational from pc; 32'hFFFF_FFFC wraps to 0. A wrapped pc_next is legal.
- Latency:
  - Earliest gnt is in the first S_REQ cycle.
  - Earliest rvalid is one cycle after gnt.
  - instr_valid rises the cycle after rvalid.
  - With zero-wait memory and decode, throughput is 1 instruction per 3 cycles plus 1 when using S_EXEC.
- Outputs are decoded from registered state only; there is no combinational path from imem_* to instr_valid.

Decomposition:
- Shared package rv32i_pkg holds:
  - the fetch state encoding (S_IDLE, S_REQ, S_WAIT, S_ISSUE, S_EXEC, S_ERR, 3 bits);
  - the RESET_PC default;
  - the ILEN=32 constant.
- No sub-module is needed. The PC register, state machine and counter fit in one module.

Test Plan:
- Reset with RESET_PC=0x100; zero-wait memory returning 0x00500093; instr_ready=1; pc_next=pc_plus4 given in the ISSUE cycle -> imem_addr sequence 0x100, 0x104, 0x108; instr=0x00500093; fetch_count=3 after 3 handshakes.
- Hold imem_gnt=0 for 4 cycles, then assert -> imem_req stays 1 with imem_addr stable for 5 cycles; exactly one transition to S_WAIT.
- Hold instr_ready=0 for 3 cycles with instr_valid=1 -> instr and pc stable; fetch_count unchanged until the handshake.
- Redirect: at pc=0x200, in S_EXEC give pc_next=0x1F0 -> next imem_addr=0x1F0; pc_plus4=0x1F4.
- pc_next=0x202 -> misalign_err=1; pc stays 0x200; imem_req=0 forever. Reset clears the error and the fetch restarts at RESET_PC.
- Assert reset during S_WAIT, then pulse imem_rvalid one cycle after release -> response discarded; instr_valid=0; a fresh fetch is issued at RESET_PC.
